// File: rtl/instruction_encoder_pkg.sv
// RV32I encoder shared types and constants.
// Formats, NOP word and legal immediate bounds.
package instruction_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'h13;

  localparam logic [31:0] NOP_INSTR = {25'd0, OP_IMM};

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

endpackage

// File: rtl/instruction_encoder_if.sv
// Request and imem-write handshake bundle.
// master drives requests, slave is the encoder.
interface instruction_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_fmt, in_opcode,
    output in_rd, in_rs1, in_rs2,
    output in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready,
    input  out_valid, out_instr,
    input  out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode,
    input  in_rd, in_rs1, in_rs2,
    input  in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready,
    output out_valid, out_instr,
    output out_addr, out_err
  );
endinterface

// File: rtl/instruction_encoder_packer.sv
// Combinational field packer: fields -> word.
// Bad immediate or format yields NOP with err.
module instruction_encoder_packer
  import instruction_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err
);

  logic signed [31:0] w_simm;
  logic               w_even;

  assign w_simm = $signed(i_imm);
  assign w_even = !i_imm[0];

  // Place immediate bits per format and range-check
  always_comb begin
    o_word = NOP_INSTR;
    o_err  = 1'b1;
    case (i_fmt)
      FMT_R: begin
        o_word = {i_funct7, i_rs2, i_rs1,
                  i_funct3, i_rd, i_opcode};
        o_err  = 1'b0;
      end
      FMT_I: begin
        o_word = {i_imm[11:0], i_rs1,
                  i_funct3, i_rd, i_opcode};
        o_err  = !(w_simm >= IMM12_MIN &&
                   w_simm <= IMM12_MAX);
      end
      FMT_S: begin
        o_word = {i_imm[11:5], i_rs2, i_rs1,
                  i_funct3, i_imm[4:0], i_opcode};
        o_err  = !(w_simm >= IMM12_MIN &&
                   w_simm <= IMM12_MAX);
      end
      FMT_B: begin
        o_word = {i_imm[12], i_imm[10:5], i_rs2,
                  i_rs1, i_funct3, i_imm[4:1],
                  i_imm[11], i_opcode};
        o_err  = !(w_even &&
                   w_simm >= IMM_B_MIN &&
                   w_simm <= IMM_B_MAX);
      end
      FMT_U: begin
        o_word = {i_imm[31:12], i_rd, i_opcode};
        o_err  = (i_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        o_word = {i_imm[20], i_imm[10:1],
                  i_imm[11], i_imm[19:12],
                  i_rd, i_opcode};
        o_err  = !(w_even &&
                   w_simm >= IMM_J_MIN &&
                   w_simm <= IMM_J_MAX);
      end
      default: o_err = 1'b1;
    endcase
    if (o_err) o_word = NOP_INSTR;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I encoder: 2-stage pipe into imem.
// Wrapping word address, saturating error count.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  instruction_encoder_if.slave bus,
  output logic [CNT_W-1:0]   err_count
);

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_hs;
  logic [31:0]       w_word;
  logic              w_err;
  logic              r_a_valid;
  logic              r_a_err;
  logic [31:0]       r_a_instr;
  logic              r_b_valid;
  logic              r_b_err;
  logic [31:0]       r_b_instr;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_err_cnt;

  instruction_encoder_packer u_packer (
    .i_fmt    (bus.in_fmt),
    .i_opcode (bus.in_opcode),
    .i_rd     (bus.in_rd),
    .i_rs1    (bus.in_rs1),
    .i_rs2    (bus.in_rs2),
    .i_funct3 (bus.in_funct3),
    .i_funct7 (bus.in_funct7),
    .i_imm    (bus.in_imm),
    .o_word   (w_word),
    .o_err    (w_err)
  );

  assign w_b_ready = !r_b_valid || bus.out_ready;
  assign w_a_ready = !r_a_valid || w_b_ready;
  assign w_hs      = r_b_valid && bus.out_ready;

  assign bus.in_ready  = w_a_ready;
  assign bus.out_valid = r_b_valid;
  assign bus.out_instr = r_b_instr;
  assign bus.out_err   = r_b_err;
  assign bus.out_addr  = r_addr;
  assign err_count     = r_err_cnt;

  // Stage A: capture the packed word on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_instr <= '0;
      r_a_err   <= 1'b0;
    end else if (w_a_ready) begin
      r_a_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_a_instr <= w_word;
        r_a_err   <= w_err;
      end
    end
  end

  // Stage B: output register, holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_instr <= '0;
      r_b_err   <= 1'b0;
    end else if (w_b_ready) begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        r_b_instr <= r_a_instr;
        r_b_err   <= r_a_err;
      end
    end
  end

  // Word address: reload on start, step per handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= BASE;
    end else if (start) begin
      r_addr <= BASE;
    end else if (w_hs) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Count errored handoffs, saturating; start clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (start) begin
      r_err_cnt <= '0;
    end else if (w_hs && r_b_err &&
                 r_err_cnt != CNT_MAX) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: reference encoder
// model, scoreboard and directed scenarios.
module tb_instruction_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [9:0]  addr;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  rec_t        log_q[$];
  int          m_addr = 0;
  int          m_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic [9:0]  prev_addr;
  logic        prev_err;

  instruction_encoder_if #(.ADDR_W(10)) bus ();

  instruction_encoder #(
    .ADDR_W(10), .BASE_ADDR(0), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference encoder from the ISA field layout.
  function automatic logic [32:0] model(
    input int fmt, input logic [31:0] op,
    input logic [31:0] rd, input logic [31:0] rs1,
    input logic [31:0] rs2, input logic [31:0] f3,
    input logic [31:0] f7, input int imm);
    logic [31:0] u;
    logic [31:0] w;
    bit ok;
    u = imm;
    w = 0;
    ok = 0;
    case (fmt)
      0: begin
        ok = 1;
        w = f7 << 25 | rs2 << 20 | rs1 << 15 |
            f3 << 12 | rd << 7 | op;
      end
      1: begin
        ok = imm >= -2048 && imm <= 2047;
        w = (u & 32'hFFF) << 20 | rs1 << 15 |
            f3 << 12 | rd << 7 | op;
      end
      2: begin
        ok = imm >= -2048 && imm <= 2047;
        w = ((u >> 5) & 32'h7F) << 25 | rs2 << 20 |
            rs1 << 15 | f3 << 12 |
            (u & 32'h1F) << 7 | op;
      end
      3: begin
        ok = (imm % 2 == 0) && imm >= -4096 &&
             imm <= 4094;
        w = ((u >> 12) & 1) << 31 |
            ((u >> 5) & 32'h3F) << 25 |
            rs2 << 20 | rs1 << 15 | f3 << 12 |
            ((u >> 1) & 32'hF) << 8 |
            ((u >> 11) & 1) << 7 | op;
      end
      4: begin
        ok = (u % 4096) == 0;
        w = (u & 32'hFFFFF000) | rd << 7 | op;
      end
      5: begin
        ok = (imm % 2 == 0) && imm >= -1048576 &&
             imm <= 1048574;
        w = ((u >> 20) & 1) << 31 |
            ((u >> 1) & 32'h3FF) << 21 |
            ((u >> 11) & 1) << 20 |
            ((u >> 12) & 32'hFF) << 12 |
            rd << 7 | op;
      end
      default: ok = 0;
    endcase
    if (!ok) w = 32'h13;
    return {!ok, w};
  endfunction

  // Scoreboard and model state, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_addr = 0;
      m_err = 0;
      prev_stall = 1'b0;
    end else begin
      logic        hs;
      logic [32:0] e;
      hs = bus.out_valid && bus.out_ready;
      chk("err_count", 32'(err_count), m_err);
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_instr", bus.out_instr, prev_instr);
        chk("stall_addr", 32'(bus.out_addr),
            32'(prev_addr));
        chk("stall_err", 32'(bus.out_err),
            32'(prev_err));
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", bus.out_instr, e[31:0]);
          chk("sb_err", 32'(bus.out_err), 32'(e[32]));
          chk("sb_addr", 32'(bus.out_addr), m_addr);
          log_q.push_back('{bus.out_instr,
                            bus.out_err,
                            bus.out_addr});
          if (!start && e[32] && m_err < 255)
            m_err++;
        end
      end
      if (start) begin
        m_err = 0;
        m_addr = 0;
      end else if (hs) begin
        m_addr = (m_addr + 1) % 1024;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(
          int'(bus.in_fmt), 32'(bus.in_opcode),
          32'(bus.in_rd), 32'(bus.in_rs1),
          32'(bus.in_rs2), 32'(bus.in_funct3),
          32'(bus.in_funct7), int'(bus.in_imm)));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_instr = bus.out_instr;
      prev_addr = bus.out_addr;
      prev_err = bus.out_err;
    end
  end

  task automatic set_req(input int fmt, input int op,
                         input int rd, input int rs1,
                         input int rs2, input int f3,
                         input int f7, input int imm);
    bus.in_fmt    = 3'(fmt);
    bus.in_opcode = 7'(op);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_imm    = imm;
  endtask

  // Offer one request until accepted (bounded)
  task automatic send(input int fmt, input int op,
                      input int rd, input int rs1,
                      input int rs2, input int f3,
                      input int f7, input int imm);
    bit done;
    done = 0;
    set_req(fmt, op, rd, rs1, rs2, f3, f7, imm);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    bit done;
    done = 0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid)
        done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int acc;
    int idx;
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_err", 32'(bus.out_err), 0);
    chk("rst_addr", 32'(bus.out_addr), 0);
    chk("rst_cnt", 32'(err_count), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: addi x1,x0,5 with latency check
    pulse_start();
    log_q.delete();
    send(1, 'h13, 1, 0, 0, 0, 0, 5);
    @(negedge clk);
    chk("t1_lat_n1", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("t1_lat_n2", 32'(bus.out_valid), 1);
    chk("t1_instr", bus.out_instr, 32'h00500093);
    chk("t1_addr", 32'(bus.out_addr), 0);
    chk("t1_err", 32'(bus.out_err), 0);
    @(posedge clk);
    #1;
    drain(20);

    // 2: lui good and bad low bits
    log_q.delete();
    send(4, 'h37, 5, 0, 0, 0, 0, 'h12345000);
    send(4, 'h37, 5, 0, 0, 0, 0, 'h12345001);
    drain(20);
    chk("t2_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_lui", log_q[0].instr, 32'h123452B7);
      chk("t2_lui_err", 32'(log_q[0].err), 0);
      chk("t2_bad", log_q[1].instr, 32'h13);
      chk("t2_bad_err", 32'(log_q[1].err), 1);
    end

    // 3: branch -4 and jal +2048, plus boundaries
    log_q.delete();
    send(3, 'h63, 0, 1, 2, 0, 0, -4);
    send(5, 'h6F, 1, 0, 0, 0, 0, 2048);
    send(3, 'h63, 0, 1, 2, 0, 0, 4094);
    send(3, 'h63, 0, 1, 2, 0, 0, 4096);
    send(3, 'h63, 0, 1, 2, 0, 0, 3);
    send(5, 'h6F, 1, 0, 0, 0, 0, -1048576);
    send(5, 'h6F, 1, 0, 0, 0, 0, 1048576);
    send(2, 'h23, 0, 2, 3, 2, 0, -2048);
    send(2, 'h23, 0, 2, 3, 2, 0, -2049);
    send(0, 'h33, 3, 1, 2, 0, 'h20, 'h7FF);
    drain(40);
    chk("t3_n", log_q.size(), 10);
    if (log_q.size() == 10) begin
      chk("t3_beq", log_q[0].instr, 32'hFE208EE3);
      chk("t3_jal", log_q[1].instr, 32'h001000EF);
      chk("t3_bmax_err", 32'(log_q[2].err), 0);
      chk("t3_bovr_err", 32'(log_q[3].err), 1);
      chk("t3_bodd_err", 32'(log_q[4].err), 1);
      chk("t3_jmin_err", 32'(log_q[5].err), 0);
      chk("t3_jovr_err", 32'(log_q[6].err), 1);
      chk("t3_smin_err", 32'(log_q[7].err), 0);
      chk("t3_sovr_err", 32'(log_q[8].err), 1);
      chk("t3_sub", log_q[9].instr, 32'h402081B3);
    end

    // 4: error words, count, then clear by start
    pulse_start();
    log_q.delete();
    send(1, 'h13, 1, 0, 0, 0, 0, 2048);
    send(7, 'h13, 1, 0, 0, 0, 0, 0);
    drain(20);
    chk("t4_cnt", 32'(err_count), 2);
    if (log_q.size() == 2) begin
      chk("t4_nop0", log_q[0].instr, 32'h13);
      chk("t4_nop1", log_q[1].instr, 32'h13);
      chk("t4_err1", 32'(log_q[1].err), 1);
    end else begin
      chk("t4_n", log_q.size(), 2);
    end
    pulse_start();
    chk("t4_clr", 32'(err_count), 0);

    // 5: stalled output with 4 back-to-back offers
    pulse_start();
    log_q.delete();
    bus.out_ready = 1'b0;
    idx = 0;
    acc = 0;
    set_req(1, 'h13, 1, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc > idx) begin
        idx = acc;
        set_req(1, 'h13, idx + 1, 0, 0, 0, 0,
                idx * 3);
      end
    end
    chk("t5_accepts", acc, 2);
    chk("t5_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc > idx) begin
        idx = acc;
        if (idx < 4)
          set_req(1, 'h13, idx + 1, 0, 0, 0, 0,
                  idx * 3);
        else
          bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    drain(20);
    chk("t5_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t5_addr", 32'(log_q[i].addr), i);
        chk("t5_rd", 32'(log_q[i].instr[11:7]),
            i + 1);
      end
    end

    // 6: async reset with words in flight
    pulse_start();
    send(0, 'h33, 1, 0, 0, 0, 0, 0);
    send(0, 'h33, 2, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_addr", 32'(bus.out_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    send(0, 'h33, 9, 0, 0, 0, 0, 0);
    drain(20);
    chk("t6_n", log_q.size(), 1);
    if (log_q.size() == 1)
      chk("t6_addr", 32'(log_q[0].addr), 0);

    // address wrap 1023 -> 0
    pulse_start();
    log_q.delete();
    for (int i = 0; i < 1025; i++)
      send(0, 'h33, i % 32, 1, 2, 0, 0, 0);
    drain(20);
    chk("wrap_n", log_q.size(), 1025);
    if (log_q.size() == 1025) begin
      chk("wrap_1023", 32'(log_q[1023].addr), 1023);
      chk("wrap_0", 32'(log_q[1024].addr), 0);
    end

    // error counter saturation
    pulse_start();
    for (int i = 0; i < 260; i++)
      send(6, 'h13, 0, 0, 0, 0, 0, 0);
    drain(20);
    chk("sat_cnt", 32'(err_count), 255);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
